sr_bank_driver: RTL and testbench
=================================

# sr_bank_driver

Command-side driver for a bank of WIDTH set/reset storage cells. It accepts a target word over a valid/ready handshake and compares it with a shadow copy of the bank contents. It then issues timed, non-overlapping set and reset pulses so that each cell ends up holding its target bit. It sits between control logic and the S/R inputs of the storage bank, and never asserts S and R for the same cell at once.

## Interface
- WIDTH, 8, number of cells driven (≥1)
- PULSE_CYC, 2, clock cycles each set/reset pulse is held (≥1)
- GAP_CYC, 1, idle cycles after each pulse phase, all S/R low (≥1)

- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  target word valid
- req_data  input  WIDTH  target cell contents
- req_ready  output  1  block can accept a request; high only in IDLE
- s_out  output  WIDTH  per-cell set strobes
- r_out  output  WIDTH  per-cell reset strobes
- q_shadow  output  WIDTH  bank contents as known to the driver
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a request completes

## Operation
- All outputs are registered. Reset values: s_out=0, r_out=0, q_shadow=0, req_ready=0, busy=1, done=0, state=INIT.
- INIT: r_out is all ones for PULSE_CYC cycles, then the FSM moves to GAP_I. This clears the physical cells so that the bank matches q_shadow=0.
- GAP_I: all strobes are low for GAP_CYC cycles, then the FSM moves to IDLE.
- IDLE: req_ready=1. A request is accepted on a clock edge with req_valid&req_ready. On acceptance the block latches req_data into tgt and computes:
  - set_m = tgt & ~q_shadow
  - clr_m = ~tgt & q_shadow
- Next state after acceptance:
  - set_m≠0 → SET
  - set_m=0, clr_m≠0 → CLR
  - both 0 → DONE
- SET: s_out=set_m for PULSE_CYC cycles, then GAP1.
- GAP1: strobes low for GAP_CYC cycles. Then CLR if clr_m≠0, else DONE.
- CLR: r_out=clr_m for PULSE_CYC cycles, then GAP2.
- GAP2: strobes low for GAP_CYC cycles, then DONE.
- DONE: lasts one cycle. done=1 and q_shadow<=tgt. Next state is IDLE.
- Invariant: (s_out & r_out)==0 in every cycle. s_out and r_out are never both nonzero in the same cycle.
- While busy, req_valid and req_data are ignored. Requests are not queued, and there is no accept during DONE.
- Reset asserted at any point, including mid-pulse, forces the reset values immediately (asynchronous). After reset deasserts, the INIT sequence runs again.

## Timing
- Call the acceptance edge cycle k. The first strobe cycle is k+1.
- Set-only request: SET at k+1..k+P, GAP1 at k+P+1..k+P+G, DONE at k+P+G+1, req_ready high at k+P+G+2.
- Set+clear request: done at k+2P+2G+1.
- Clear-only request: done at k+P+G+1.
- No-change request: done at k+1 with no strobes.
- After reset release: r_out all ones for P cycles, then G gap cycles, then req_ready=1.
- Phase counter width is $clog2(max(PULSE_CYC,GAP_CYC)+1). It reloads on every state entry.

## Structure
- A shared package holds the state enum (INIT, GAP_I, IDLE, SET, GAP1, CLR, GAP2, DONE) and the counter-width function.
- One sub-module, sr_phase_timer: a loadable down-counter with a load value and a zero flag. The FSM instantiates it once for all pulse and gap phases.
- Mask computation and the output registers stay in the top-level module.

## Test plan
All scenarios use WIDTH=8, P=2, G=1.
- Reset release → r_out=0xFF for 2 cycles, then 0x00 for 1 cycle, then req_ready=1; q_shadow=0x00 throughout.
- Request 0xA5 from shadow 0x00 → s_out=0xA5 at k+1..k+2, r_out stays 0, done at k+4, q_shadow=0xA5.
- Request 0x0F from shadow 0xA5 → s_out=0x0A at k+1..k+2, gap at k+3, r_out=0xA0 at k+4..k+5, gap at k+6, done at k+7, q_shadow=0x0F.
- Request 0x0F from shadow 0x0F → no strobes, done at k+1, req_ready high again at k+2.
- Assert rst in the second SET cycle → s_out=0 in the same cycle, without waiting for a clock edge. q_shadow=0, then the INIT sequence runs after release.
- req_valid held with changing req_data while busy → no extra acceptance and tgt unchanged. Checker asserts (s_out & r_out)==0 every cycle.

Source files
------------

// File: rtl/sr_bank_driver_pkg.sv
// Shared types for the set/reset bank driver: FSM states and phase-counter sizing.
package sr_bank_driver_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_GAP_I = 3'd1,
        ST_IDLE  = 3'd2,
        ST_SET   = 3'd3,
        ST_GAP1  = 3'd4,
        ST_CLR   = 3'd5,
        ST_GAP2  = 3'd6,
        ST_DONE  = 3'd7
    } sr_state_e;

    // Counter must hold the longest phase length, including the INIT reload of PULSE_CYC.
    function automatic int cnt_w(input int p, input int g);
        int m;
        m = (p > g) ? p : g;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// Request handshake and strobe/status bundle between control logic and the bank driver.
interface sr_bank_driver_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic [WIDTH-1:0] req_data;
    logic             req_ready;
    logic [WIDTH-1:0] s_out;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] q_shadow;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_data,
        input  req_ready, s_out, r_out, q_shadow, busy, done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, s_out, r_out, q_shadow, busy, done
    );
endinterface

// File: rtl/sr_phase_timer.sv
// Loadable down-counter shared by all pulse and gap phases; zero_o marks the last phase cycle.
module sr_phase_timer #(
    parameter int CW      = 2,
    parameter int RST_VAL = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt_q <= CW'(RST_VAL);
        else if (load_i)       cnt_q <= load_val_i;
        else if (cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_bank_driver.sv
// Drives S/R strobes so a WIDTH-cell set/reset bank ends up holding each accepted target word.
module sr_bank_driver
    import sr_bank_driver_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic                clk,
    input  logic                rst,
    sr_bank_driver_if.slave     bus
);

    localparam int CW = cnt_w(PULSE_CYC, GAP_CYC);

    sr_state_e        st_q, st_d;
    logic [WIDTH-1:0] tgt_q, tgt_d, set_m_q, set_m_d, clr_m_q, clr_m_d;
    logic [WIDTH-1:0] s_q, s_d, r_q, r_d, q_q, q_d;
    logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic             accept, ph_zero, ph_load;
    logic [CW-1:0]    ph_val;

    assign accept = ready_q & bus.req_valid;

    always_comb begin
        tgt_d   = accept ? bus.req_data : tgt_q;
        set_m_d = accept ? (bus.req_data & ~q_q) : set_m_q;
        clr_m_d = accept ? (~bus.req_data & q_q) : clr_m_q;
    end

    // INIT is not re-entered by a transition, so the timer reset value sizes the first clear pulse;
    // the reset cycle itself shows r_out=0, hence PULSE_CYC rather than PULSE_CYC-1.
    sr_phase_timer #(.CW(CW), .RST_VAL(PULSE_CYC)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .zero_o     (ph_zero)
    );

    assign ph_load = (st_d != st_q);

    always_comb begin
        case (st_d)
            ST_SET, ST_CLR:            ph_val = CW'(PULSE_CYC - 1);
            ST_GAP_I, ST_GAP1, ST_GAP2: ph_val = CW'(GAP_CYC - 1);
            default:                   ph_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= ST_INIT;
        else     st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_INIT:  if (ph_zero) st_d = ST_GAP_I;
            ST_GAP_I: if (ph_zero) st_d = ST_IDLE;
            ST_IDLE:
                if (accept) begin
                    if (set_m_d != '0)      st_d = ST_SET;
                    else if (clr_m_d != '0) st_d = ST_CLR;
                    else                    st_d = ST_DONE;
                end
            ST_SET:   if (ph_zero) st_d = ST_GAP1;
            ST_GAP1:  if (ph_zero) st_d = (clr_m_q != '0) ? ST_CLR : ST_DONE;
            ST_CLR:   if (ph_zero) st_d = ST_GAP2;
            ST_GAP2:  if (ph_zero) st_d = ST_DONE;
            ST_DONE:  st_d = ST_IDLE;
            default:  st_d = ST_INIT;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with st_q.
    always_comb begin
        s_d     = '0;
        r_d     = '0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        q_d     = q_q;
        case (st_d)
            ST_INIT: r_d = '1;
            ST_SET:  s_d = set_m_d;
            ST_CLR:  r_d = clr_m_d;
            ST_IDLE: begin ready_d = 1'b1; busy_d = 1'b0; end
            ST_DONE: begin done_d = 1'b1; q_d = tgt_d; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q   <= '0;
            set_m_q <= '0;
            clr_m_q <= '0;
            s_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            set_m_q <= set_m_d;
            clr_m_q <= clr_m_d;
            s_q     <= s_d;
            r_q     <= r_d;
            q_q     <= q_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.s_out     = s_q;
    assign bus.r_out     = r_q;
    assign bus.q_shadow  = q_q;
    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver with WIDTH=8, PULSE_CYC=2, GAP_CYC=1.
module tb_sr_bank_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sr_bank_driver_if #(.WIDTH(8)) bus ();

    sr_bank_driver #(.WIDTH(8), .PULSE_CYC(2), .GAP_CYC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ((bus.s_out & bus.r_out) !== 8'h00) begin
                bad++;
                $display("FAIL overlap s_out=%h r_out=%h", bus.s_out, bus.r_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] er [1:4];
        logic       erdy [1:4];
        er   = '{8'hFF, 8'hFF, 8'h00, 8'h00};
        erdy = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        repeat (2) tick();
        total++;
        if (bus.s_out !== 8'h00 || bus.r_out !== 8'h00 || bus.q_shadow !== 8'h00 ||
            bus.req_ready !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got s=%h r=%h q=%h rdy=%b busy=%b done=%b want 00 00 00 0 1 0",
                     bus.s_out, bus.r_out, bus.q_shadow, bus.req_ready, bus.busy, bus.done);
        end
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (bus.r_out !== er[c] || bus.s_out !== 8'h00 || bus.req_ready !== erdy[c] ||
                bus.q_shadow !== 8'h00) begin
                bad++;
                $display("FAIL init_seq cyc%0d got r=%h s=%h rdy=%b q=%h want r=%h s=00 rdy=%b q=00",
                         c, bus.r_out, bus.s_out, bus.req_ready, bus.q_shadow, er[c], erdy[c]);
            end
        end
    endtask

    task automatic test_set_only();
        logic [7:0] es [1:5];
        logic       ed [1:5];
        logic       ey [1:5];
        es = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ey = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.req_valid = 1'b1;
        bus.req_data  = 8'hA5;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.req_valid = 1'b0;
            total++;
            if (bus.s_out !== es[c] || bus.r_out !== 8'h00 || bus.done !== ed[c] || bus.req_ready !== ey[c]) begin
                bad++;
                $display("FAIL set_only cyc%0d got s=%h r=%h done=%b rdy=%b want s=%h r=00 done=%b rdy=%b",
                         c, bus.s_out, bus.r_out, bus.done, bus.req_ready, es[c], ed[c], ey[c]);
            end
        end
        total++;
        if (bus.q_shadow !== 8'hA5) begin
            bad++;
            $display("FAIL set_only_shadow got %h want a5", bus.q_shadow);
        end
    endtask

    task automatic test_set_clr();
        logic [7:0] es [1:8];
        logic [7:0] er [1:8];
        logic       ed [1:8];
        es = '{8'h0A, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        er = '{8'h00, 8'h00, 8'h00, 8'hA0, 8'hA0, 8'h00, 8'h00, 8'h00};
        ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h0F;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.req_valid = 1'b0;
            total++;
            if (bus.s_out !== es[c] || bus.r_out !== er[c] || bus.done !== ed[c]) begin
                bad++;
                $display("FAIL set_clr cyc%0d got s=%h r=%h done=%b want s=%h r=%h done=%b",
                         c, bus.s_out, bus.r_out, bus.done, es[c], er[c], ed[c]);
            end
        end
        total++;
        if (bus.q_shadow !== 8'h0F || bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL set_clr_end got q=%h rdy=%b want q=0f rdy=1", bus.q_shadow, bus.req_ready);
        end
    endtask

    task automatic test_no_change();
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h0F;
        tick();
        bus.req_valid = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.s_out !== 8'h00 || bus.r_out !== 8'h00 || bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL no_change_k1 got done=%b s=%h r=%h rdy=%b want 1 00 00 0",
                     bus.done, bus.s_out, bus.r_out, bus.req_ready);
        end
        tick();
        total++;
        if (bus.req_ready !== 1'b1 || bus.done !== 1'b0 || bus.q_shadow !== 8'h0F) begin
            bad++;
            $display("FAIL no_change_k2 got rdy=%b done=%b q=%h want 1 0 0f",
                     bus.req_ready, bus.done, bus.q_shadow);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] es [1:8];
        logic [7:0] er [1:8];
        es = '{8'h30, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        er = '{8'h00, 8'h00, 8'h00, 8'h0C, 8'h0C, 8'h00, 8'h00, 8'h00};
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h33;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.req_valid = (c < 7);
            bus.req_data  = 8'($urandom);
            total++;
            if (bus.s_out !== es[c] || bus.r_out !== er[c]) begin
                bad++;
                $display("FAIL busy_ignore cyc%0d got s=%h r=%h want s=%h r=%h",
                         c, bus.s_out, bus.r_out, es[c], er[c]);
            end
        end
        for (int c = 0; c < 2; c++) begin
            total++;
            if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.q_shadow !== 8'h33) begin
                bad++;
                $display("FAIL busy_idle%0d got rdy=%b busy=%b q=%h want 1 0 33",
                         c, bus.req_ready, bus.busy, bus.q_shadow);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_pulse();
        bus.req_valid = 1'b1;
        bus.req_data  = 8'hCC;
        tick();
        bus.req_valid = 1'b0;
        tick();
        total++;
        if (bus.s_out !== 8'hCC) begin
            bad++;
            $display("FAIL mid_set_pulse got s=%h want cc", bus.s_out);
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.s_out !== 8'h00 || bus.q_shadow !== 8'h00 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got s=%h q=%h busy=%b rdy=%b want 00 00 1 0",
                     bus.s_out, bus.q_shadow, bus.busy, bus.req_ready);
        end
        test_reset();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        test_reset();
        test_set_only();
        test_set_clr();
        test_no_change();
        test_busy_ignore();
        test_reset_mid_pulse();
        test_set_only();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
